mlp_argmax_scorer: RTL and testbench
====================================

# mlp_argmax_scorer

Downstream scoring stage of the MLP. It takes the output-layer neuron values of each test case as a serial valid/ready stream. For each case it selects the index of the largest value (argmax) and compares it with the true label. It counts correct classifications over a full run of test cases, then raises `done` with the final `accuracy` count.

## Interface
- `n`, 8: width of one output-layer value, two's-complement signed
- `size_of_output_layer`, 10: values (classes) per test case
- `clog2_size_of_output_layer`, 4: index/label width
- `number_of_test_cases`, 750: cases per run
- `clog2_number_of_test_cases`, 10: width of case counter and `accuracy`; must satisfy number_of_test_cases < 2**clog2_number_of_test_cases
- `clk` input 1: single clock, rising edge
- `rst` input 1: reset, asynchronous, active-low
- `start` input 1: begins a run; sampled only in IDLE or DONE
- `in_valid` input 1: `in_value`/`in_label` valid
- `in_ready` output 1: block accepts an element this cycle
- `in_value` input n: one output-layer value, signed
- `in_label` input clog2_size_of_output_layer: true class of the current case; sampled only with element 0
- `pred_valid` output 1: one-cycle pulse per finished case
- `pred_label` output clog2_size_of_output_layer: argmax index; valid while `pred_valid`
- `pred_correct` output 1: `pred_label` equals true label; valid while `pred_valid`
- `done` output 1: run complete; held until the next `start` or reset
- `accuracy` output clog2_number_of_test_cases: count of correct cases; final when `done`

## Operation
- FSM states: IDLE, COLLECT, DECIDE, DONE.
- IDLE:
  - `in_ready` = 0.
  - `start` = 1 → COLLECT; clears correct_count, case_idx and elem_idx.
- COLLECT:
  - `in_ready` = 1; an element is accepted on `in_valid & in_ready`.
  - Element 0: best ← `in_value`, best_idx ← 0, label_reg ← `in_label`.
  - Element k > 0: if `in_value` > best (signed, strict), then best ← `in_value`, best_idx ← k.
  - Ties keep the lowest index.
  - On acceptance of element size_of_output_layer−1, elem_idx ← 0 → DECIDE.
  - `in_valid` low stalls the case indefinitely; no timeout.
- DECIDE (exactly one cycle):
  - `in_ready` = 0, `pred_valid` = 1, `pred_label` = best_idx, `pred_correct` = (best_idx == label_reg).
  - correct_count increments if correct.
  - If case_idx == number_of_test_cases−1 → DONE; otherwise case_idx increments → COLLECT.
- DONE:
  - `done` = 1, `accuracy` = correct_count, `in_ready` = 0.
  - `start` = 1 → clear all counters, `done` ← 0, → COLLECT.
- `start` is ignored in COLLECT and DECIDE.
- `accuracy` always reflects correct_count and is final only while `done` = 1.
- Arithmetic:
  - Comparisons are signed n-bit.
  - correct_count ≤ number_of_test_cases, so it never wraps.
  - `in_label` values ≥ size_of_output_layer are not rejected; such a case simply never matches.

## Timing
- Reset (`rst` = 0, any state, any time):
  - State → IDLE immediately.
  - `in_ready`, `pred_valid`, `pred_label`, `pred_correct`, `done`, `accuracy` all go to 0; every internal register goes to 0.
  - A partially collected case is discarded.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Latency: last element accepted at edge t → `pred_valid` high in cycle t+1. For the last case, `done` is high from cycle t+2.
- Throughput: with `in_valid` held high, one case per size_of_output_layer+1 cycles.
- Full run minimum: number_of_test_cases × (size_of_output_layer+1) + 1 cycles from `start`.
- `start` in DONE: `done` deasserts on the next edge and `in_ready` rises in the same cycle.

## Test plan
- Reset: assert `rst` = 0 mid-case after 4 elements, then release and pulse `start` → every output reads 0 during reset. The next 10 elements form a fresh case; `pred_valid` fires once, with no stale best/label.
- Single case: values [−5, 3, 100, 7, 0, 1, 2, 3, 4, 5], label 2 → `pred_valid` one cycle after the 10th accept, `pred_label` = 2, `pred_correct` = 1.
- Tie and signed compare:
  - Values all 0x10 except idx 3 and 7 = 0x50 → `pred_label` = 3.
  - All 0x80 (−128) except idx 9 = 0xFF (−1) → `pred_label` = 9 (checks a signed, not unsigned, compare).
- Backpressure: random `in_valid` gaps across a case → same `pred_label` as the gap-free run; exactly 10 handshakes per case.
- Full run: 750 cases, the first 600 labelled with their true argmax and the remaining 150 mislabelled → 750 `pred_valid` pulses, `done` = 1, `accuracy` = 600. Both hold for 100 idle cycles, and `in_ready` stays 0.
- Restart: pulse `start` in DONE and run 5 cases, 3 correct → `done` drops on the next edge, then `done` = 1 with `accuracy` = 3 only if number_of_test_cases = 5 (parameter override). A `start` pulse mid-COLLECT has no effect.

Source files
------------

// File: rtl/mlp_argmax_scorer.sv
// ---------------------------------------------------------------------------
// mlp_argmax_scorer
//
// Scoring stage at the end of the MLP. Each test case arrives as a serial
// stream of output-layer values. The block keeps a running maximum to find
// the argmax, compares it with the case's true label, and counts correct
// classifications over a full run of test cases. When the run ends it holds
// done_o high with the final accuracy count.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_i        begins a run; only looked at in IDLE or DONE
//   in_valid_i     in_value_i / in_label_i carry an element
//   in_ready_o     an element is accepted this cycle if in_valid_i is high
//   in_value_i     one signed output-layer value
//   in_label_i     true class of the case; only taken with element 0
//   pred_valid_o   one-cycle pulse per finished case
//   pred_label_o   argmax index, meaningful while pred_valid_o
//   pred_correct_o argmax matches the label, meaningful while pred_valid_o
//   done_o         run complete, held until the next start or reset
//   accuracy_o     number of correctly classified cases so far
// ---------------------------------------------------------------------------
module mlp_argmax_scorer #(
  parameter int n                          = 8,
  parameter int size_of_output_layer       = 10,
  parameter int clog2_size_of_output_layer = 4,
  parameter int number_of_test_cases       = 750,
  parameter int clog2_number_of_test_cases = 10
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  start_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [n-1:0]                          in_value_i,
  input  logic [clog2_size_of_output_layer-1:0] in_label_i,
  output logic                                  pred_valid_o,
  output logic [clog2_size_of_output_layer-1:0] pred_label_o,
  output logic                                  pred_correct_o,
  output logic                                  done_o,
  output logic [clog2_number_of_test_cases-1:0] accuracy_o
);

  localparam logic [clog2_size_of_output_layer-1:0] LastElem =
    clog2_size_of_output_layer'(size_of_output_layer - 1);
  localparam logic [clog2_size_of_output_layer-1:0] ElemOne =
    clog2_size_of_output_layer'(1);
  localparam logic [clog2_number_of_test_cases-1:0] LastCase =
    clog2_number_of_test_cases'(number_of_test_cases - 1);
  localparam logic [clog2_number_of_test_cases-1:0] CaseOne =
    clog2_number_of_test_cases'(1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DECIDE,
    DONE
  } state_t;

  state_t                                  state_q, state_d;
  logic signed [n-1:0]                     bestValue_q, bestValue_d;
  logic [clog2_size_of_output_layer-1:0]   bestIdx_q, bestIdx_d;
  logic [clog2_size_of_output_layer-1:0]   labelReg_q, labelReg_d;
  logic [clog2_size_of_output_layer-1:0]   elemIdx_q, elemIdx_d;
  logic [clog2_number_of_test_cases-1:0]   caseIdx_q, caseIdx_d;
  logic [clog2_number_of_test_cases-1:0]   correctCount_q, correctCount_d;

  // State and datapath registers. Reset clears everything, which also
  // throws away any case that was only partly collected.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      bestValue_q    <= '0;
      bestIdx_q      <= '0;
      labelReg_q     <= '0;
      elemIdx_q      <= '0;
      caseIdx_q      <= '0;
      correctCount_q <= '0;
    end else begin
      state_q        <= state_d;
      bestValue_q    <= bestValue_d;
      bestIdx_q      <= bestIdx_d;
      labelReg_q     <= labelReg_d;
      elemIdx_q      <= elemIdx_d;
      caseIdx_q      <= caseIdx_d;
      correctCount_q <= correctCount_d;
    end
  end

  // Next-state logic. Element 0 seeds the running maximum unconditionally.
  // Later elements replace it only when strictly larger, so ties keep the
  // lowest index. DECIDE lasts one cycle and is where the score is updated.
  always_comb begin
    state_d        = state_q;
    bestValue_d    = bestValue_q;
    bestIdx_d      = bestIdx_q;
    labelReg_d     = labelReg_q;
    elemIdx_d      = elemIdx_q;
    caseIdx_d      = caseIdx_q;
    correctCount_d = correctCount_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d        = COLLECT;
          elemIdx_d      = '0;
          caseIdx_d      = '0;
          correctCount_d = '0;
        end
      end

      COLLECT: begin
        if (in_valid_i) begin
          if (elemIdx_q == '0) begin
            bestValue_d = $signed(in_value_i);
            bestIdx_d   = '0;
            labelReg_d  = in_label_i;
          end else if ($signed(in_value_i) > bestValue_q) begin
            bestValue_d = $signed(in_value_i);
            bestIdx_d   = elemIdx_q;
          end

          if (elemIdx_q == LastElem) begin
            elemIdx_d = '0;
            state_d   = DECIDE;
          end else begin
            elemIdx_d = elemIdx_q + ElemOne;
          end
        end
      end

      DECIDE: begin
        if (bestIdx_q == labelReg_q) begin
          correctCount_d = correctCount_q + CaseOne;
        end
        if (caseIdx_q == LastCase) begin
          state_d = DONE;
        end else begin
          caseIdx_d = caseIdx_q + CaseOne;
          state_d   = COLLECT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded purely from registered state, so no input reaches
  // an output combinationally. The prediction fields are forced to zero
  // outside DECIDE so they never show a stale case.
  assign in_ready_o     = (state_q == COLLECT);
  assign pred_valid_o   = (state_q == DECIDE);
  assign pred_label_o   = (state_q == DECIDE) ? bestIdx_q : '0;
  assign pred_correct_o = (state_q == DECIDE) && (bestIdx_q == labelReg_q);
  assign done_o         = (state_q == DONE);
  assign accuracy_o     = correctCount_q;

endmodule

// File: tb/tb_mlp_argmax_scorer.sv
// ---------------------------------------------------------------------------
// tb_mlp_argmax_scorer
//
// Bench for the argmax scorer. A monitor watches the input handshakes every
// cycle, rebuilds each case in an array, works out the argmax and the score
// directly from the classification rules, and compares every DUT output
// against that on each falling edge. The main process drives directed and
// random cases and pins a few results to hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mlp_argmax_scorer;

  localparam int N  = 8;
  localparam int S  = 10;
  localparam int LW = 4;
  localparam int NC = 750;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_value = '0;
  logic [LW-1:0] in_label = '0;
  logic          in_ready;
  logic          pred_valid;
  logic [LW-1:0] pred_label;
  logic          pred_correct;
  logic          done;
  logic [CW-1:0] accuracy;

  int testsRun = 0;
  int testsFailed = 0;

  logic signed [N-1:0] caseVals[S];

  mlp_argmax_scorer #(
    .n                          (N),
    .size_of_output_layer       (S),
    .clog2_size_of_output_layer (LW),
    .number_of_test_cases       (NC),
    .clog2_number_of_test_cases (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_value_i     (in_value),
    .in_label_i     (in_label),
    .pred_valid_o   (pred_valid),
    .pred_label_o   (pred_label),
    .pred_correct_o (pred_correct),
    .done_o         (done),
    .accuracy_o     (accuracy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Argmax of the case currently held in caseVals, lowest index on ties.
  function automatic int refArgmax();
    int bi = 0;
    for (int k = 1; k < S; k++) begin
      if (caseVals[k] > caseVals[bi]) bi = k;
    end
    return bi;
  endfunction

  // Behavioural model and per-cycle compare. The model tracks only the
  // things a user sees: are we collecting, is a verdict due, is the run
  // finished, how many correct so far.
  logic signed [N-1:0] mVals[S];
  int  mElem = 0, mCase = 0, mAcc = 0, mExpLabel = 0;
  int  mLabel = 0;
  bit  mActive = 0, mPending = 0, mDone = 0, mExpCorrect = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("reset in_ready", int'(in_ready), 0);
        checkOutput("reset pred_valid", int'(pred_valid), 0);
        checkOutput("reset pred_label", int'(pred_label), 0);
        checkOutput("reset pred_correct", int'(pred_correct), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset accuracy", int'(accuracy), 0);
        mActive = 0; mPending = 0; mDone = 0;
        mAcc = 0; mCase = 0; mElem = 0;
      end else begin
        checkOutput("in_ready", int'(in_ready), int'(mActive));
        checkOutput("pred_valid", int'(pred_valid), int'(mPending));
        if (mPending) begin
          checkOutput("pred_label", int'(pred_label), mExpLabel);
          checkOutput("pred_correct", int'(pred_correct), int'(mExpCorrect));
        end
        checkOutput("done", int'(done), int'(mDone));
        checkOutput("accuracy", int'(accuracy), mAcc);

        if (mPending) begin
          mAcc += int'(mExpCorrect);
          mCase++;
          mPending = 0;
          if (mCase == NC) mDone = 1;
          else mActive = 1;
        end else if (mActive) begin
          if (in_valid) begin
            mVals[mElem] = in_value;
            if (mElem == 0) mLabel = int'(in_label);
            mElem++;
            if (mElem == S) begin
              mExpLabel = 0;
              for (int k = 1; k < S; k++) begin
                if (mVals[k] > mVals[mExpLabel]) mExpLabel = k;
              end
              mExpCorrect = (mExpLabel == mLabel);
              mPending = 1;
              mActive = 0;
              mElem = 0;
            end
          end
        end else if (start) begin
          mActive = 1; mDone = 0; mAcc = 0; mCase = 0; mElem = 0;
        end
      end
    end
  end

  // Sends the first numElems elements of caseVals. gapPct is the chance
  // of idling a cycle. Called and returns at posedge+1.
  task automatic applyStimulus(input int label, input int numElems, input int gapPct);
    int  budget;
    bit  accepted;
    int  lab;
    for (int k = 0; k < numElems; k++) begin
      accepted = 0;
      budget = 0;
      while (!accepted) begin
        in_valid = ($urandom_range(0, 99) >= gapPct);
        in_value = caseVals[k];
        lab = (k == 0) ? label : int'($urandom_range(0, 15));
        in_label = lab[LW-1:0];
        @(negedge clk);
        if (in_valid && in_ready) accepted = 1;
        @(posedge clk);
        #1;
        budget++;
        if (!accepted && budget > 200) begin
          checkOutput("handshake timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Checks the verdict one cycle after the last accept.
  task automatic waitPred(input int expLabel, input int expCorrect);
    @(negedge clk);
    checkOutput("latency pred_valid", int'(pred_valid), 1);
    checkOutput("literal pred_label", int'(pred_label), expLabel);
    checkOutput("literal pred_correct", int'(pred_correct), expCorrect);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic fillRandom();
    for (int k = 0; k < S; k++) caseVals[k] = N'($urandom);
  endtask

  // Main stimulus sequence.
  initial begin
    int r;
    int a;
    int lab;
    int singleVals[S] = '{-5, 3, 100, 7, 0, 1, 2, 3, 4, 5};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of a case, after 4 elements.
    pulseStart();
    fillRandom();
    applyStimulus(1, 4, 0);
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset in_ready", int'(in_ready), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulseStart();

    // Fresh case after reset, peak at index 6.
    for (int k = 0; k < S; k++) begin
      r = int'($urandom_range(0, 200)) - 100;
      caseVals[k] = r[N-1:0];
    end
    caseVals[6] = 8'sd120;
    applyStimulus(6, S, 0);
    waitPred(6, 1);

    // Hand-computed single case.
    for (int k = 0; k < S; k++) caseVals[k] = singleVals[k][N-1:0];
    applyStimulus(2, S, 0);
    waitPred(2, 1);

    // Tie: lowest index of the two maxima wins.
    for (int k = 0; k < S; k++) caseVals[k] = 8'sh10;
    caseVals[3] = 8'sh50;
    caseVals[7] = 8'sh50;
    applyStimulus(7, S, 0);
    waitPred(3, 0);

    // Signed compare: -1 beats -128.
    for (int k = 0; k < S; k++) caseVals[k] = 8'sh80;
    caseVals[9] = 8'shFF;
    applyStimulus(9, S, 0);
    waitPred(9, 1);

    // Backpressure: same case without and with gaps.
    fillRandom();
    a = refArgmax();
    applyStimulus(a, S, 0);
    waitPred(a, 1);
    applyStimulus(a, S, 50);
    waitPred(a, 1);

    // Full run from a clean reset.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulseStart();
    for (int c = 0; c < NC; c++) begin
      fillRandom();
      a = refArgmax();
      lab = (c < 600) ? a : (a + 1) % S;
      applyStimulus(lab, S, (c % 7 == 0) ? 30 : 0);
      waitPred(a, (c < 600) ? 1 : 0);
    end
    @(negedge clk);
    checkOutput("run done", int'(done), 1);
    checkOutput("run accuracy", int'(accuracy), 600);
    repeat (100) @(negedge clk);
    checkOutput("hold done", int'(done), 1);
    checkOutput("hold accuracy", int'(accuracy), 600);
    checkOutput("hold in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;

    // Restart from DONE; done drops on the next edge.
    pulseStart();
    @(negedge clk);
    checkOutput("restart done", int'(done), 0);
    checkOutput("restart in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        pulseStart();
        @(negedge clk);
        checkOutput("mid-collect start accuracy", int'(accuracy), 1);
        @(posedge clk);
        #1;
      end
      fillRandom();
      a = refArgmax();
      lab = (c % 2 == 0) ? a : (a + 3) % S;
      applyStimulus(lab, S, 20);
      waitPred(a, (c % 2 == 0) ? 1 : 0);
    end
    @(negedge clk);
    checkOutput("restart accuracy", int'(accuracy), 3);
    checkOutput("restart not done", int'(done), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
